fft8_frame_controller: RTL
==========================

Name: fft8_frame_controller

Overview:
Sequencer for the 8-point CORDIC FFT core. Accepts complex samples one per handshake, assembles a frame of 8, and drives the core's parallel inputs while holding core_en high for a fixed latency. It then captures the packed core outputs and streams the 8 result bins out serially. It sits between a serial sample source/sink and the FFT core and is the only agent that drives the core's en.

Parameters:
DW, 16, width of each real/imag sample and result.
CORE_LAT, 40, cycles from core_en rising until core outputs are valid; legal range 1..255.

Ports:
clock  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
s_valid  in  1  input sample valid.
s_ready  out  1  controller can accept a sample.
s_re  in  DW  input sample, real part, signed.
s_im  in  DW  input sample, imag part, signed.
core_en  out  1  enable to the FFT core.
core_xin  out  8*DW  packed real inputs; sample k at [k*DW +: DW].
core_yin  out  8*DW  packed imag inputs; same packing.
core_xout  in  8*DW+1  packed real results; bin k at [k*DW +: DW]; MSB ignored.
core_yout  in  8*DW+1  packed imag results; same packing.
m_valid  out  1  output bin valid.
m_ready  in  1  sink accepts the bin.
m_re  out  DW  result bin, real part.
m_im  out  DW  result bin, imag part.
m_idx  out  3  bin index 0..7.
m_last  out  1  high with bin 7.
busy  out  1  high in RUN or UNLOAD.

Behaviour:
- Reset (async, immediate): state=LOAD, wcnt=0, rcnt=0, lat_cnt=0.
  - Input buffer and output buffer cleared to 0.
  - core_en=0, m_valid=0, s_ready=0, busy=0, m_idx=0, m_last=0.
  - All outputs are registered. s_ready rises on the first clock edge after reset deasserts.
- LOAD:
  - s_ready=1.
  - On s_valid&&s_ready: ibuf[wcnt] <= {s_re,s_im}, wcnt++.
  - When sample 7 is accepted: s_ready drops on that same edge, state -> RUN, core_en=1 from the next cycle, lat_cnt=0.
  - Sample 0 is the first accepted sample.
- RUN:
  - core_en=1. core_xin/core_yin are driven from ibuf and held stable for the whole state.
  - lat_cnt increments each cycle.
  - In the cycle where lat_cnt==CORE_LAT-1: obuf <= core_xout/core_yout slices, state -> UNLOAD, core_en=0 next cycle.
  - core_en is therefore high for exactly CORE_LAT cycles.
- UNLOAD:
  - m_valid=1; m_re/m_im = obuf[rcnt]; m_idx=rcnt; m_last=(rcnt==7).
  - On m_valid&&m_ready: rcnt++.
  - Data is held stable while m_ready=0.
  - After bin 7 is accepted: m_valid=0, rcnt=0, wcnt=0, state -> LOAD, s_ready=1 on the same edge.
- Frames do not overlap; s_ready=0 throughout RUN and UNLOAD.
- Width rules:
  - Samples are passed through unscaled.
  - Results are sliced unscaled; bit 8*DW of core_xout/core_yout is discarded.
  - No saturation or rounding in this block.
- Reset mid-frame: partial input frame discarded, core_en drops immediately, any unsent bins lost, m_valid=0.
- s_valid while s_ready=0: ignored; no state change.

Decomposition:
- Shared package fft8_pkg: N_PTS=8, IDX_W=3, state enum {LOAD,RUN,UNLOAD}, slice helper function for packed 8-slot buses.
- One sub-module is natural: fft8_frame_buf, an 8-entry complex register file with write port and packed/serial read. Instantiated twice, once as input buffer and once as output buffer.
- No other hierarchy.

Test Plan:
- Bench core stub: 8-slot packed outputs equal to core_xin + k in slot k, presented CORE_LAT cycles after core_en rises. Parameters CORE_LAT=4, DW=16.
1. Impulse: frame (256,256),(0,0)x7 -> core_en high exactly 4 cycles; bins stream out as re=256,1,2..7 and im=256,1,2..7; m_idx 0..7; m_last only on bin 7.
2. Input backpressure: s_valid toggled every other cycle with ramp 1..10 -> only samples 1..8 accepted; s_ready=0 from the edge accepting sample 8; samples 9 and 10 remain pending.
3. Output backpressure: m_ready=0 for 5 cycles at bin 3 -> m_re/m_idx=3 held stable; no bin dropped or duplicated; total 8 handshakes.
4. Input stability: core_xin/core_yin do not change during any RUN cycle, even while s_valid toggles with new data.
5. Reset mid-RUN at lat_cnt=2 -> core_en=0, m_valid=0, busy=0 asynchronously; s_ready=1 one cycle after release; next frame (ramp 1..8) yields re=1,3,5..15.
6. Back-to-back: s_valid held high with 16 samples, m_ready=1 -> two complete frames; s_ready low for exactly CORE_LAT+8 cycles between frames; both frames' outputs are correct.

Source files
------------

// File: rtl/fft8_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fft8_pkg
// Description : Shared constants, FSM state type and bus-slicing helper for
//               the 8-point FFT frame controller.
// Revision    : 1.0 - initial release
// ============================================================================
package fft8_pkg;

    localparam int N_PTS = 8;
    localparam int IDX_W = 3;

    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        RUN    = 2'd1,
        UNLOAD = 2'd2
    } state_t;

    // Bit offset of slot 'slot' in a packed bus of equally sized slots.
    function automatic int unsigned slot_lsb(input int unsigned slot, input int unsigned dw);
        return slot * dw;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fft8_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : fft8_frame_buf
// Description : 8-entry complex register file with a single-slot write port,
//               a whole-frame parallel load, and packed plus serial reads.
// Revision    : 1.0 - initial release
// ============================================================================
module fft8_frame_buf
    import fft8_pkg::*;
#(
    parameter int DW = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DW-1:0]         i_wr_re,
    input  logic [DW-1:0]         i_wr_im,
    input  logic                  i_ld_en,
    input  logic [N_PTS*DW-1:0]   i_ld_re,
    input  logic [N_PTS*DW-1:0]   i_ld_im,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DW-1:0]         o_rd_re,
    output logic [DW-1:0]         o_rd_im,
    output logic [N_PTS*DW-1:0]   o_pk_re,
    output logic [N_PTS*DW-1:0]   o_pk_im
);

    for (genvar k = 0; k < N_PTS; k++) begin : g_slot
        localparam int unsigned c_lsb = slot_lsb(k, DW);

        logic [DW-1:0] r_re;
        logic [DW-1:0] r_im;

        // A frame load takes priority; the two ports are never used together.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                r_re <= '0;
                r_im <= '0;
            end else if (i_ld_en) begin
                r_re <= i_ld_re[c_lsb +: DW];
                r_im <= i_ld_im[c_lsb +: DW];
            end else if (i_wr_en && (i_wr_idx == IDX_W'(k))) begin
                r_re <= i_wr_re;
                r_im <= i_wr_im;
            end
        end

        assign o_pk_re[c_lsb +: DW] = r_re;
        assign o_pk_im[c_lsb +: DW] = r_im;
    end

    assign o_rd_re = o_pk_re[slot_lsb(32'(i_rd_idx), DW) +: DW];
    assign o_rd_im = o_pk_im[slot_lsb(32'(i_rd_idx), DW) +: DW];

endmodule
`default_nettype wire

// File: rtl/fft8_frame_controller.sv
`default_nettype none
// ============================================================================
// Module      : fft8_frame_controller
// Description : Collects 8 complex samples, runs the FFT core for a fixed
//               latency, then streams the 8 result bins out serially.
// Revision    : 1.0 - initial release
// ============================================================================
module fft8_frame_controller
    import fft8_pkg::*;
#(
    parameter int DW       = 16,
    parameter int CORE_LAT = 40
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DW-1:0]         s_re,
    input  logic [DW-1:0]         s_im,
    output logic                  core_en,
    output logic [N_PTS*DW-1:0]   core_xin,
    output logic [N_PTS*DW-1:0]   core_yin,
    input  logic [N_PTS*DW:0]     core_xout,
    input  logic [N_PTS*DW:0]     core_yout,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DW-1:0]         m_re,
    output logic [DW-1:0]         m_im,
    output logic [IDX_W-1:0]      m_idx,
    output logic                  m_last,
    output logic                  busy
);

    localparam logic [7:0]       c_lat_last = 8'(CORE_LAT - 1);
    localparam logic [IDX_W-1:0] c_last_idx = IDX_W'(N_PTS - 1);

    state_t             r_state;
    logic [IDX_W-1:0]   r_wcnt;
    logic [IDX_W-1:0]   r_rcnt;
    logic [7:0]         r_lat_cnt;

    logic               w_accept;
    logic               w_capture;
    logic               w_m_fire;
    logic [IDX_W-1:0]   w_rd_idx;
    logic [DW-1:0]      w_obuf_re;
    logic [DW-1:0]      w_obuf_im;
    logic [N_PTS*DW-1:0] w_core_xres;
    logic [N_PTS*DW-1:0] w_core_yres;

    logic [DW-1:0]       w_unused_ibuf_re;
    logic [DW-1:0]       w_unused_ibuf_im;
    logic [N_PTS*DW-1:0] w_unused_obuf_pk_re;
    logic [N_PTS*DW-1:0] w_unused_obuf_pk_im;
    logic                w_unused_xmsb;
    logic                w_unused_ymsb;

    assign w_accept    = (r_state == LOAD) && s_valid && s_ready;
    assign w_capture   = (r_state == RUN) && (r_lat_cnt == c_lat_last);
    assign w_m_fire    = (r_state == UNLOAD) && m_valid && m_ready;
    // The output register always holds the current bin, so the buffer is read one ahead.
    assign w_rd_idx    = r_rcnt + IDX_W'(1);
    assign w_core_xres = core_xout[N_PTS*DW-1:0];
    assign w_core_yres = core_yout[N_PTS*DW-1:0];
    assign w_unused_xmsb = core_xout[N_PTS*DW];
    assign w_unused_ymsb = core_yout[N_PTS*DW];

    fft8_frame_buf #(.DW(DW)) u_ibuf (
        .clk      (clock),
        .rst      (reset),
        .i_wr_en  (w_accept),
        .i_wr_idx (r_wcnt),
        .i_wr_re  (s_re),
        .i_wr_im  (s_im),
        .i_ld_en  (1'b0),
        .i_ld_re  ('0),
        .i_ld_im  ('0),
        .i_rd_idx ('0),
        .o_rd_re  (w_unused_ibuf_re),
        .o_rd_im  (w_unused_ibuf_im),
        .o_pk_re  (core_xin),
        .o_pk_im  (core_yin)
    );

    fft8_frame_buf #(.DW(DW)) u_obuf (
        .clk      (clock),
        .rst      (reset),
        .i_wr_en  (1'b0),
        .i_wr_idx ('0),
        .i_wr_re  ('0),
        .i_wr_im  ('0),
        .i_ld_en  (w_capture),
        .i_ld_re  (w_core_xres),
        .i_ld_im  (w_core_yres),
        .i_rd_idx (w_rd_idx),
        .o_rd_re  (w_obuf_re),
        .o_rd_im  (w_obuf_im),
        .o_pk_re  (w_unused_obuf_pk_re),
        .o_pk_im  (w_unused_obuf_pk_im)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state   <= LOAD;
            r_wcnt    <= '0;
            r_rcnt    <= '0;
            r_lat_cnt <= '0;
            s_ready   <= 1'b0;
            core_en   <= 1'b0;
            busy      <= 1'b0;
            m_valid   <= 1'b0;
            m_re      <= '0;
            m_im      <= '0;
            m_idx     <= '0;
            m_last    <= 1'b0;
        end else begin
            case (r_state)
                LOAD: begin
                    s_ready <= 1'b1;
                    if (w_accept) begin
                        r_wcnt <= r_wcnt + IDX_W'(1);
                        if (r_wcnt == c_last_idx) begin
                            s_ready   <= 1'b0;
                            core_en   <= 1'b1;
                            busy      <= 1'b1;
                            r_lat_cnt <= '0;
                            r_state   <= RUN;
                        end
                    end
                end

                RUN: begin
                    r_lat_cnt <= r_lat_cnt + 8'd1;
                    // Bin 0 goes straight to the output register; the rest come from obuf.
                    if (w_capture) begin
                        core_en <= 1'b0;
                        m_valid <= 1'b1;
                        m_re    <= w_core_xres[DW-1:0];
                        m_im    <= w_core_yres[DW-1:0];
                        m_idx   <= '0;
                        m_last  <= 1'b0;
                        r_rcnt  <= '0;
                        r_state <= UNLOAD;
                    end
                end

                UNLOAD: begin
                    if (w_m_fire) begin
                        if (r_rcnt == c_last_idx) begin
                            m_valid <= 1'b0;
                            m_last  <= 1'b0;
                            m_idx   <= '0;
                            r_rcnt  <= '0;
                            r_wcnt  <= '0;
                            s_ready <= 1'b1;
                            busy    <= 1'b0;
                            r_state <= LOAD;
                        end else begin
                            r_rcnt <= w_rd_idx;
                            m_idx  <= w_rd_idx;
                            m_re   <= w_obuf_re;
                            m_im   <= w_obuf_im;
                            m_last <= (w_rd_idx == c_last_idx);
                        end
                    end
                end

                default: r_state <= LOAD;
            endcase
        end
    end

endmodule
`default_nettype wire
